// File: rtl/phy_cfg_pkg.sv
// rtl/phy_cfg_pkg.sv - state encoding, MDIO field widths and parameter-table helpers for the PHY config sequencer
package phy_cfg_pkg;

  localparam int PHY_AD_W   = 5;
  localparam int RG_AD_W    = 5;
  localparam int DATA_W     = 16;
  localparam int MAX_WRITES = 16;
  localparam int IDX_W      = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ISSUE  = 3'd2,
    S_SETTLE = 3'd3,
    S_VERIFY = 3'd4,
    S_VWAIT  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  function automatic logic [RG_AD_W-1:0] table_addr(
    input logic [RG_AD_W*MAX_WRITES-1:0] addrs,
    input logic [IDX_W-1:0]              i
  );
    return addrs[RG_AD_W*int'(i) +: RG_AD_W];
  endfunction

  function automatic logic [DATA_W-1:0] table_data(
    input logic [DATA_W*MAX_WRITES-1:0] data,
    input logic [IDX_W-1:0]             i
  );
    return data[DATA_W*int'(i) +: DATA_W];
  endfunction

endpackage

// File: rtl/phy_cfg_settle_timer.sv
// rtl/phy_cfg_settle_timer.sv - 32b counter with clear/enable and terminal-count flag
module phy_cfg_settle_timer #(
  parameter logic [31:0] TERMINAL = 32'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  output logic [31:0] count,
  output logic        tc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 32'd1;
    end
  end

  assign tc = enable && (count == TERMINAL - 32'd1);

endmodule

// File: rtl/phy_cfg_sequencer.sv
// rtl/phy_cfg_sequencer.sv - boot-time PHY register programmer walking an MDIO write table
// Optional readback verification of every write: PHY_CFG_READBACK_EN
module phy_cfg_sequencer
  import phy_cfg_pkg::*;
#(
  parameter int                            NUM_WRITES    = 3,
  parameter logic [PHY_AD_W-1:0]           PHY_ADDR      = 5'd1,
  parameter logic [RG_AD_W*NUM_WRITES-1:0] REG_ADDRS     = {5'd0, 5'd4, 5'd9},
  parameter logic [DATA_W*NUM_WRITES-1:0]  REG_DATA      = {16'h9000, 16'h0000, 16'h0200},
  parameter logic [31:0]                   SETTLE_CYCLES = 32'd1000000,
  parameter int                            AUTO_START    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                req_valid,
  input  logic                req_ready,
  output logic                req_write,
  output logic [PHY_AD_W-1:0] req_phy_ad,
  output logic [RG_AD_W-1:0]  req_rg_ad,
  output logic [DATA_W-1:0]   req_data,
  input  logic                rsp_valid,
  input  logic [DATA_W-1:0]   rsp_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [IDX_W-1:0]    entry_idx
);

  localparam logic [RG_AD_W*MAX_WRITES-1:0] ADDR_TBL = (RG_AD_W*MAX_WRITES)'(REG_ADDRS);
  localparam logic [DATA_W*MAX_WRITES-1:0]  DATA_TBL = (DATA_W*MAX_WRITES)'(REG_DATA);
  localparam logic [IDX_W-1:0]              LAST_IDX = IDX_W'(NUM_WRITES - 1);

  state_t               state;
  state_t               next_state;
  logic                 reset_q;
  logic [IDX_W-1:0]     idx;
  logic                 settle_tc;
  logic [31:0]          unused_settle_count;
  logic [RG_AD_W-1:0]   cur_addr;
  logic [DATA_W-1:0]    cur_data;
  logic                 start_evt;
  logic                 run_start;
  logic                 last_entry;
  logic                 entry_end;

  assign cur_addr   = table_addr(ADDR_TBL, idx);
  assign cur_data   = table_data(DATA_TBL, idx);
  // reset_q is high only on the first cycle after reset falls, which is the auto-start cycle
  assign start_evt  = start || ((AUTO_START != 0) && reset_q);
  assign run_start  = ((state == S_IDLE) || (state == S_DONE)) && start_evt;
  assign last_entry = (idx == LAST_IDX);

  phy_cfg_settle_timer #(
    .TERMINAL(SETTLE_CYCLES)
  ) u_settle (
    .clk   (clk),
    .reset (reset),
    .clear ((state != S_SETTLE) || settle_tc),
    .enable(state == S_SETTLE),
    .count (unused_settle_count),
    .tc    (settle_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      reset_q <= 1'b1;
    end else begin
      state   <= next_state;
      reset_q <= 1'b0;
    end
  end

  // The NEXT decision is folded into the exit of SETTLE/VWAIT so each entry costs 2 + wait + SETTLE_CYCLES
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: if (start_evt) next_state = S_LOAD;
      S_LOAD:         next_state = S_ISSUE;
      S_ISSUE:        if (req_ready) next_state = S_SETTLE;
`ifdef PHY_CFG_READBACK_EN
      S_SETTLE:       if (settle_tc) next_state = S_VERIFY;
      S_VERIFY:       if (req_ready) next_state = S_VWAIT;
      S_VWAIT:        if (rsp_valid) next_state = last_entry ? S_DONE : S_LOAD;
`else
      S_SETTLE:       if (settle_tc) next_state = last_entry ? S_DONE : S_LOAD;
`endif
      default:        next_state = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE:            busy = 1'b0;
      S_DONE:            begin busy = 1'b0; done = 1'b1; end
      S_ISSUE, S_VERIFY: req_valid = 1'b1;
      default:           ;
    endcase
  end

`ifdef PHY_CFG_READBACK_EN
  logic err;

  assign entry_end = (state == S_VWAIT) && rsp_valid;

  always_ff @(posedge clk) begin
    if (reset || run_start) begin
      err <= 1'b0;
    end else if (entry_end && (rsp_data != cur_data)) begin
      err <= 1'b1;
    end
  end

  assign error = err;
`else
  logic unused_rsp;

  assign entry_end  = settle_tc;
  assign unused_rsp = ^{rsp_valid, rsp_data};
  assign error      = 1'b0;
`endif

  // Payload only changes in LOAD (and at settle end for the readback), never while a request is pending
  always_ff @(posedge clk) begin
    if (reset) begin
      idx       <= '0;
      req_write <= 1'b0;
      req_rg_ad <= '0;
      req_data  <= '0;
    end else begin
      if (run_start) begin
        idx <= '0;
      end else if (entry_end && !last_entry) begin
        idx <= idx + 4'd1;
      end
      if (state == S_LOAD) begin
        req_write <= 1'b1;
        req_rg_ad <= cur_addr;
        req_data  <= cur_data;
      end
`ifdef PHY_CFG_READBACK_EN
      else if (settle_tc) begin
        req_write <= 1'b0;
      end
`endif
    end
  end

  assign req_phy_ad = PHY_ADDR;
  assign entry_idx  = idx;

endmodule

// File: tb/tb_phy_cfg_sequencer.sv
// tb/tb_phy_cfg_sequencer.sv - scoreboard bench for phy_cfg_sequencer (also exercises PHY_CFG_READBACK_EN builds)
module tb_phy_cfg_sequencer;

`ifdef PHY_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        req_ready = 1'b1;
  logic        req_valid, req_write, busy, done, error;
  logic [4:0]  req_phy_ad, req_rg_ad;
  logic [15:0] req_data;
  logic [3:0]  entry_idx;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        resp_v = 1'b0;
  logic        stray_v = 1'b0;
  logic [15:0] resp_d = 16'h0;
  logic        bad_entry0 = 1'b0;

  assign rsp_valid = resp_v | stray_v;
  assign rsp_data  = stray_v ? 16'hdead : resp_d;

  typedef struct packed {
    logic [4:0]  rg;
    logic [15:0] data;
    logic        wr;
    int          gap;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = 0;

  phy_cfg_sequencer #(
    .NUM_WRITES   (3),
    .SETTLE_CYCLES(32'd10),
    .AUTO_START   (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_phy_ad(req_phy_ad),
    .req_rg_ad (req_rg_ad),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .entry_idx (entry_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_data(input logic [4:0] rg);
    case (rg)
      5'd9:    return 16'h0200;
      5'd4:    return 16'h0000;
      5'd0:    return 16'h9000;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic push_entry(input logic [4:0] rg, input logic [15:0] d, input int gap);
    sb.push_back('{rg: rg, data: d, wr: 1'b1, gap: (RB ? 0 : gap)});
    if (RB) sb.push_back('{rg: rg, data: d, wr: 1'b0, gap: 0});
  endtask

  task automatic push_run(input int gap1);
    push_entry(5'd9, 16'h0200, 0);
    push_entry(5'd4, 16'h0000, gap1);
    push_entry(5'd0, 16'h9000, 12);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, done=%0b expected 1", name, done);
    end
  endtask

  task automatic wait_write(input logic [3:0] idx);
    int n = 0;
    while (!(req_valid && req_write && entry_idx == idx) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!(req_valid && req_write && entry_idx == idx)) begin
      checks++;
      errors++;
      $display("FAIL wait_write: timeout for entry %0d, entry_idx=%0d", idx, entry_idx);
    end
  endtask

  // Monitor: every accepted request is matched against the scoreboard
  initial begin
    logic        prev_stall;
    logic [26:0] prev_pl;
    exp_t        e;
    prev_stall = 1'b0;
    prev_pl    = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && req_valid)
          check("payload_stable", 32'({req_phy_ad, req_rg_ad, req_data, req_write}), 32'(prev_pl));
        if (req_valid && req_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_accept: got reg %0d write %0b, expected no request", req_rg_ad, req_write);
          end else begin
            e = sb.pop_front();
            check("req_rg_ad", 32'(req_rg_ad), 32'(e.rg));
            check("req_data", 32'(req_data), 32'(e.data));
            check("req_write", 32'(req_write), 32'(e.wr));
            check("req_phy_ad", 32'(req_phy_ad), 32'd1);
            if (e.gap > 0) check("accept_gap", 32'(cyc - last_acc), 32'(e.gap));
          end
          last_acc = cyc;
        end
        prev_stall = req_valid && !req_ready;
        prev_pl    = {req_phy_ad, req_rg_ad, req_data, req_write};
      end
    end
  end

  // Read responder for the readback build
  initial begin
    logic [4:0] rg;
    forever begin
      @(negedge clk);
      if (!reset && req_valid && req_ready && !req_write) begin
        rg = req_rg_ad;
        @(negedge clk);
        #1;
        resp_v = 1'b1;
        resp_d = (bad_entry0 && rg == 5'd9) ? 16'h0201 : exp_data(rg);
        @(negedge clk);
        #1 resp_v = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    // Test 1: reset state, then auto-started run with ready always high
    push_run(12);
    repeat (3) @(negedge clk);
    check("rst_req_valid", 32'(req_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_entry_idx", 32'(entry_idx), 32'd0);
    check("rst_req_rg_ad", 32'(req_rg_ad), 32'd0);
    check("rst_req_data", 32'(req_data), 32'd0);
    check("rst_req_write", 32'(req_write), 32'd0);
    #1 reset = 1'b0;
    wait_done("t1_done");
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_entry_idx", 32'(entry_idx), 32'd2);
    check("t1_error", 32'(error), 32'd0);
    check("t1_queue_empty", 32'(sb.size()), 32'd0);

    // Test 2/4: start from DONE, start while busy, ready stalled 5 cycles on entry 1
    bad_entry0 = RB;
    push_run(17);
    #1 start = 1'b1;
    @(negedge clk);
    check("t2_busy_after_start", 32'(busy), 32'd1);
    check("t2_done_cleared", 32'(done), 32'd0);
    check("t2_entry_idx_start", 32'(entry_idx), 32'd0);
    #1 start = 1'b0;
    wait_write(4'd0);
    @(negedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    check("t2_busy_start_ignored", 32'(entry_idx), 32'd0);
    n = 0;
    while (entry_idx != 4'd1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("t2_reach_entry1", 32'(entry_idx), 32'd1);
    @(posedge clk);
    #1 req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_stall_valid", 32'(req_valid), 32'd1);
    end
    @(posedge clk);
    #1 req_ready = 1'b1;
    wait_done("t2_done");
    check("t2_done", 32'(done), 32'd1);
    check("t2_error", 32'(error), RB ? 32'd1 : 32'd0);
    check("t2_entry_idx", 32'(entry_idx), 32'd2);
    check("t2_queue_empty", 32'(sb.size()), 32'd0);

    // Test 3/6: reset during SETTLE of entry 1, auto-rerun with stray rsp_valid in SETTLE
    @(negedge clk);
    bad_entry0 = 1'b0;
    push_entry(5'd9, 16'h0200, 0);
    push_entry(5'd4, 16'h0000, 12);
    #1 start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    wait_write(4'd1);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("t3_req_valid", 32'(req_valid), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_entry_idx", 32'(entry_idx), 32'd0);
    check("t3_done", 32'(done), 32'd0);
    check("t3_queue_left", 32'(sb.size()), RB ? 32'd1 : 32'd0);
    sb.delete();
    push_run(12);
    #1 reset = 1'b0;
    wait_write(4'd0);
    @(negedge clk);
    #1 stray_v = 1'b1;
    @(negedge clk);
    #1 stray_v = 1'b0;
    wait_done("t3_done");
    check("t3_done", 32'(done), 32'd1);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_error", 32'(error), 32'd0);
    check("t3_entry_idx", 32'(entry_idx), 32'd2);
    check("t3_queue_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
